inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch stage directly upstream of the single-cycle datapath. It generates word addresses (PC increments by 1) toward an instruction memory that may insert wait states, and buffers returned words in a small prefetch FIFO. It presents one instruction, with its PC and PC+1, per cycle to the datapath. Taken branches, jumps and `jr`/`jal` redirect the unit, which flushes all buffered words.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'd0: first fetch address after reset.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word address of the request.
- `imem_ack`  in  1  memory returns `imem_rdata` for current request this cycle.
- `imem_rdata`  in  32  instruction word; valid only when `imem_req & imem_ack`.
- `redirect`  in  1  datapath-computed next PC differs from sequential; one-cycle pulse.
- `redirect_pc`  in  32  new fetch address; valid with `redirect`.
- `inst_ready`  in  1  datapath consumes the head instruction this cycle.
- `inst_valid`  out  1  FIFO non-empty.
- `inst`  out  32  head instruction; 0 when empty.
- `inst_pc`  out  32  address of head instruction; 0 when empty.
- `inst_pc_plus1`  out  32  `inst_pc + 1`, modulo 2^32; 0 when empty.

## Operation
- Registers: `fpc` (next address to fetch), `req_addr` (drives `imem_addr`), FIFO `count`, state.
- States:
  - IDLE: `imem_req=0`.
  - REQ: `imem_req=1`, `imem_addr=req_addr`.
  - DRAIN: `imem_req=1` on a stale address; response is discarded.
- Memory handshake: once `imem_req` rises, `imem_req` and `imem_addr` are held stable until `imem_ack`. A request completes in the cycle where `imem_req & imem_ack`. At most one request is outstanding.
- Fetch transitions:
  - REQ with ack and no redirect: push {rdata, req_addr}, `fpc<=fpc+1`.
  - Next state is REQ with `req_addr<=fpc+1` if `count_next<DEPTH`, else IDLE.
  - IDLE: go to REQ with `req_addr<=fpc` when `count<DEPTH`.
- FIFO push and pop in the same cycle are both performed; `count` is unchanged.
- `count_next = count + push − pop`, where `pop = inst_valid & inst_ready`.
- Redirect has priority over push and pop. The FIFO is emptied (`count<=0`) and `fpc<=redirect_pc`. Behaviour by state:
  - IDLE: go to REQ, `req_addr<=redirect_pc`.
  - REQ with ack in the same cycle: discard data, stay REQ, `req_addr<=redirect_pc`.
  - REQ without ack: go to DRAIN, `req_addr` held.
  - DRAIN: `fpc<=redirect_pc` only; the latest redirect wins.
- DRAIN with ack: discard data, go to REQ, `req_addr<=fpc`.
- `fpc` and `req_addr` wrap from 32'hFFFFFFFF to 0. FIFO pointers wrap modulo DEPTH.
- Asserting `inst_ready` with `inst_valid=0` is ignored.

## Timing
- Reset (`rst=0`), asynchronous:
  - state IDLE, `fpc=RESET_PC`, `req_addr=RESET_PC`, `count=0`.
  - `imem_req=0`, `imem_addr=RESET_PC`, `inst_valid=0`.
  - `inst`, `inst_pc` and `inst_pc_plus1` are 0.
- Outputs go to reset values immediately on reset assertion, mid-request included. A request abandoned by reset is never completed.
- Reset sequence:
  - First rising edge after `rst` rises: IDLE→REQ.
  - `imem_req=1` from cycle 1; `imem_addr=RESET_PC`.
- Latency with zero-wait memory (ack same cycle as req): `inst_valid` is high the cycle after ack. Sustained throughput is 1 instruction/cycle.
- Redirect to first valid instruction is 2 cycles (redirect edge→REQ, ack edge→valid), plus wait states, plus the DRAIN time if a request was pending.
- All outputs are registered or derived from registered FIFO state. There is no combinational path from `imem_ack`/`redirect` to `inst_*`.

## Structure
- Package `ifu_pkg`:
  - `ifu_state_t` enum {IDLE, REQ, DRAIN}
  - `WORD_W=32`
  - `ifu_entry_t` struct {inst, pc}
- Sub-module `ifu_fifo`: synchronous FIFO of `ifu_entry_t` with DEPTH entries.
  - Controls: push, pop, flush (flush highest priority), `count` output.
  - Storage is not reset; the head output is gated to 0 when empty.
- Top module holds the FSM, `fpc`, `req_addr` and the PC+1 adder.

## Test plan
1. Reset release, zero-wait memory, `inst_ready=1`: `imem_addr` sequence is 0,1,2,3,… on consecutive cycles; `inst_pc` is 0,1,2,… one cycle behind; `inst_pc_plus1=inst_pc+1`.
2. `inst_ready=0`, zero-wait memory: exactly 4 acks; `imem_req` then drops with `count=4`. Raising `inst_ready` for one cycle yields `inst_pc=0` and one new request at address 4.
3. Memory with 3 wait states, `redirect` with `redirect_pc=100` in the 2nd wait cycle:
   - `imem_addr` stays at the old address until ack, and that data is never visible.
   - The next request is at 100; first `inst_pc=100`.
4. Redirect with same-cycle ack and a simultaneous pop, `redirect_pc=40` while `count=2`: the FIFO is empty next cycle and the next `imem_addr=40`.
5. `redirect_pc=32'hFFFFFFFF`, zero-wait memory: the fetched `inst_pc` sequence is FFFFFFFF, 0, 1, and `inst_pc_plus1=0` for the first.
6. `rst` pulled low mid-request with a full FIFO: `imem_req` and `inst_valid` drop in the same cycle. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifu_pkg.sv
// Instruction fetch unit shared types.
// Fetch FSM states and the prefetch FIFO entry layout.
package ifu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } ifu_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] pc;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO holding fetched words with their PCs.
// Flush beats push and pop; head reads as zero when empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  ifu_entry_t wdata,
  output ifu_entry_t head,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  ifu_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign do_push = push & ~flush & (count != FULL);
  assign do_pop  = pop & ~flush & (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: request FSM, fetch PC and prefetch FIFO.
// Redirects flush buffered words; stale in-flight requests are drained.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] inst_pc,
  output logic [WORD_W-1:0] inst_pc_plus1
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ifu_state_t state, state_nx;
  logic [WORD_W-1:0] fpc, fpc_nx;
  logic [WORD_W-1:0] req_addr, req_addr_nx;
  logic [CW-1:0] count, count_nx;
  logic push, pop;
  ifu_entry_t wdata, head;

  assign pop  = inst_valid & inst_ready;
  assign push = (state == REQ) & imem_ack & ~redirect;
  assign count_nx = count + CW'(push) - CW'(pop);
  assign wdata = '{inst: imem_rdata, pc: req_addr};

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  always_comb begin
    state_nx    = state;
    fpc_nx      = fpc;
    req_addr_nx = req_addr;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          state_nx    = REQ;
          fpc_nx      = redirect_pc;
          req_addr_nx = redirect_pc;
        end else if (count < FULL) begin
          state_nx    = REQ;
          req_addr_nx = fpc;
        end
      end
      REQ: begin
        if (redirect) begin
          fpc_nx = redirect_pc;
          if (imem_ack) req_addr_nx = redirect_pc;
          else state_nx = DRAIN;
        end else if (imem_ack) begin
          fpc_nx = fpc + 32'd1;
          if (count_nx < FULL) req_addr_nx = fpc + 32'd1;
          else state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (redirect) fpc_nx = redirect_pc;
        // the latest redirect target is the one fetched
        if (imem_ack) begin
          state_nx    = REQ;
          req_addr_nx = fpc_nx;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nx;
      fpc      <= fpc_nx;
      req_addr <= req_addr_nx;
    end
  end

  assign imem_req      = (state != IDLE);
  assign imem_addr     = req_addr;
  assign inst_valid    = (count != '0);
  assign inst          = head.inst;
  assign inst_pc       = head.pc;
  assign inst_pc_plus1 = inst_valid ? head.pc + 32'd1 : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit with a wait-state memory model.
// Expected request addresses and instruction PCs are queued by stimulus.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus1;

  int n_cmp = 0;
  int n_err = 0;
  int waits = 0;
  int wcnt = 0;
  int ack_cnt = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  assign imem_ack   = imem_req && (wcnt >= waits);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (imem_req && imem_ack) wcnt <= 0;
    else if (imem_req) wcnt <= wcnt + 1;
  end

  inst_fetch_unit #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .inst_ready    (inst_ready),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_pc_plus1 (inst_pc_plus1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (imem_req && imem_ack) begin
        ack_cnt++;
        if (exp_addr.size() != 0) begin
          logic [31:0] ea;
          ea = exp_addr.pop_front();
          chk("sb imem_addr", imem_addr, ea);
        end
      end
      if (inst_valid && inst_ready && exp_pc.size() != 0) begin
        logic [31:0] ep;
        ep = exp_pc.pop_front();
        chk("sb inst_pc", inst_pc, ep);
        chk("sb inst", inst, mem_word(ep));
        chk("sb inst_pc_plus1", inst_pc_plus1, ep + 32'd1);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " imem_req"}, 32'(imem_req), 32'd0);
    chk({nm, " imem_addr"}, imem_addr, 32'd0);
    chk({nm, " inst_valid"}, 32'(inst_valid), 32'd0);
    chk({nm, " inst"}, inst, 32'd0);
    chk({nm, " inst_pc"}, inst_pc, 32'd0);
    chk({nm, " inst_pc_plus1"}, inst_pc_plus1, 32'd0);
  endtask

  task automatic drained(input string nm);
    chk({nm, " addr left"}, 32'(exp_addr.size()), 32'd0);
    chk({nm, " pc left"}, 32'(exp_pc.size()), 32'd0);
  endtask

  // Reset asserted mid-cycle, released just after a rising edge.
  task automatic do_reset(input int w, input logic rdy);
    @(posedge clk);
    #3;
    rst = 1'b0;
    redirect = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk_reset_outs("reset");
    exp_addr.delete();
    exp_pc.delete();
    ack_cnt = 0;
    waits = w;
    tick(2);
    rst = 1'b1;
    inst_ready = rdy;
  endtask

  initial begin
    // T1: streaming, zero-wait memory
    do_reset(0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(32'(i));
      exp_pc.push_back(32'(i));
    end
    tick();
    chk("t1 c1 imem_req", 32'(imem_req), 32'd1);
    chk("t1 c1 imem_addr", imem_addr, 32'd0);
    chk("t1 c1 inst_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("t1 c2 inst_valid", 32'(inst_valid), 32'd1);
    chk("t1 c2 inst_pc", inst_pc, 32'd0);
    chk("t1 c2 imem_addr", imem_addr, 32'd1);
    tick(9);
    drained("t1");

    // T2: datapath stalled until the FIFO fills
    do_reset(0, 1'b0);
    for (int i = 0; i < 5; i++) exp_addr.push_back(32'(i));
    exp_pc.push_back(32'd0);
    tick(8);
    chk("t2 acks", 32'(ack_cnt), 32'd4);
    chk("t2 imem_req", 32'(imem_req), 32'd0);
    chk("t2 inst_valid", 32'(inst_valid), 32'd1);
    chk("t2 inst_pc", inst_pc, 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick(4);
    chk("t2 acks after pop", 32'(ack_cnt), 32'd5);
    chk("t2 imem_req idle", 32'(imem_req), 32'd0);
    chk("t2 head", inst_pc, 32'd1);
    drained("t2");

    // T3: redirect during wait states forces a drain
    do_reset(3, 1'b1);
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd100);
    exp_addr.push_back(32'd101);
    exp_pc.push_back(32'd100);
    exp_pc.push_back(32'd101);
    tick(2);
    redirect = 1'b1;
    redirect_pc = 32'd100;
    tick();
    redirect = 1'b0;
    chk("t3 hold imem_req", 32'(imem_req), 32'd1);
    chk("t3 hold imem_addr", imem_addr, 32'd0);
    tick(2);
    chk("t3 new imem_addr", imem_addr, 32'd100);
    chk("t3 no stale", 32'(inst_valid), 32'd0);
    tick(10);
    drained("t3");

    // T4: redirect with same-cycle ack and pop
    do_reset(0, 1'b0);
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd1);
    exp_addr.push_back(32'd2);
    exp_addr.push_back(32'd40);
    exp_addr.push_back(32'd41);
    exp_pc.push_back(32'd0);
    exp_pc.push_back(32'd40);
    exp_pc.push_back(32'd41);
    tick(3);
    chk("t4 head before", inst_pc, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'd40;
    inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("t4 flushed", 32'(inst_valid), 32'd0);
    chk("t4 imem_addr", imem_addr, 32'd40);
    tick(4);
    drained("t4");

    // T5: fetch across the address wrap
    do_reset(0, 1'b1);
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'hFFFF_FFFF);
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd1);
    exp_pc.push_back(32'hFFFF_FFFF);
    exp_pc.push_back(32'd0);
    exp_pc.push_back(32'd1);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    chk("t5 c2 inst_valid", 32'(inst_valid), 32'd0);
    chk("t5 c2 imem_addr", imem_addr, 32'hFFFF_FFFF);
    tick();
    chk("t5 inst_pc", inst_pc, 32'hFFFF_FFFF);
    chk("t5 inst_pc_plus1", inst_pc_plus1, 32'd0);
    tick(4);
    drained("t5");

    // T6: reset asserted while a request is pending
    do_reset(0, 1'b0);
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'(i));
    exp_pc.push_back(32'd0);
    tick(8);
    chk("t6 full imem_req", 32'(imem_req), 32'd0);
    chk("t6 full inst_valid", 32'(inst_valid), 32'd1);
    waits = 5;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick(2);
    chk("t6 pending imem_req", 32'(imem_req), 32'd1);
    chk("t6 pending imem_addr", imem_addr, 32'd4);
    drained("t6 pre");
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("t6 async");
    tick(2);
    waits = 0;
    ack_cnt = 0;
    rst = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(32'(i));
      exp_pc.push_back(32'(i));
    end
    tick(7);
    drained("t6 post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
